// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR averaging buffer: FSM encoding,
// datapath widths, and small helpers for block length and result scaling.
package sar_pkg;

    localparam int SAR_W     = 8;
    localparam int ACC_W     = 11;
    localparam int CNT_W     = 3;
    localparam int SEL_W     = 2;
    localparam int LVL_W     = 5;
    localparam int DEPTH_DEF = 4;

    typedef enum logic {
        S_idle  = 1'b0,
        S_accum = 1'b1
    } acc_state_t;

    typedef struct packed {
        logic             vld;
        logic [SAR_W-1:0] data;
    } push_req_t;

    // Block length N = 2^sel, sized one bit wider than cnt so N=8 is representable.
    function automatic logic [CNT_W:0] blk_len(input logic [SEL_W-1:0] sel);
        return (CNT_W+1)'(1) << sel;
    endfunction

    // Divide by N and truncate to the sample width (no rounding).
    function automatic logic [SAR_W-1:0] avg_trunc(input logic [ACC_W-1:0] acc,
                                                    input logic [SEL_W-1:0] sel);
        logic [ACC_W-1:0] shifted;
        shifted = acc >> sel;
        return shifted[SAR_W-1:0];
    endfunction

endpackage

// File: rtl/sar_result_fifo.sv
// Result FIFO with explicit occupancy count; head is gated to zero when empty.
// A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
module sar_result_fifo
    import sar_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [SAR_W-1:0] push_data,
    input  logic             pop,
    output logic [SAR_W-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][SAR_W-1:0] mem;
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sar_avg_buffer.sv
// Block-averages SAR conversion results over N = 2^avg_sel samples and queues
// each block result in a small FIFO; tracks dropped results as sticky overflow.
module sar_avg_buffer
    import sar_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             eoc,
    input  logic [SAR_W-1:0] sar,
    input  logic [SEL_W-1:0] avg_sel,
    input  logic             flush,
    output logic [SAR_W-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [LVL_W-1:0] level,
    output logic             overflow
);

    acc_state_t       state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SEL_W-1:0] n_sel, n_sel_nxt;
    logic [ACC_W-1:0] sum;
    push_req_t        push_req;
    logic             pop;
    logic             full;
    logic             empty;

    assign dout_valid = !empty;
    assign pop        = dout_valid && dout_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= S_idle;
            acc   <= '0;
            cnt   <= '0;
            n_sel <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            n_sel <= n_sel_nxt;
        end
    end

    // avg_sel is only sampled on the first sample of a block.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        n_sel_nxt = n_sel;
        push_req  = '0;
        sum       = acc + ACC_W'(sar);
        if (eoc) begin
            case (state)
                S_idle: begin
                    n_sel_nxt = avg_sel;
                    if (avg_sel == '0) begin
                        push_req.vld  = 1'b1;
                        push_req.data = sar;
                    end else begin
                        acc_nxt   = ACC_W'(sar);
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = S_accum;
                    end
                end
                S_accum: begin
                    if (({1'b0, cnt} + (CNT_W+1)'(1)) == blk_len(n_sel)) begin
                        push_req.vld  = 1'b1;
                        push_req.data = avg_trunc(sum, n_sel);
                        acc_nxt       = '0;
                        cnt_nxt       = '0;
                        state_nxt     = S_idle;
                    end else begin
                        acc_nxt = sum;
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = S_idle;
            endcase
        end
    end

    // A pop in the same cycle makes room, so a full FIFO only drops without one.
    always_ff @(posedge clk) begin
        if (rst || flush)
            overflow <= 1'b0;
        else if (push_req.vld && full && !pop)
            overflow <= 1'b1;
    end

    sar_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push_req.vld),
        .push_data (push_req.data),
        .pop       (pop),
        .head      (dout),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

endmodule

// File: doc/sar_avg_buffer.md
SAR_AVG_BUFFER -- requirements
Module: sar_avg_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, result FIFO entries; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 eoc  input  1  one-cycle end-of-conversion pulse from the SAR logic.
REQ-005 sar  input  8  conversion result; valid in the cycle eoc is high.
REQ-006 avg_sel  input  2  averaging factor code; block length N = 2^avg_sel (1, 2, 4, 8).
REQ-007 flush  input  1  synchronous clear of accumulator, FIFO and overflow.
REQ-008 dout  output  8  FIFO head result; 0 when FIFO empty.
REQ-009 dout_valid  output  1  FIFO non-empty.
REQ-010 dout_ready  input  1  consumer accept; pop occurs when dout_valid && dout_ready.
REQ-011 level  output  5  current FIFO occupancy, 0..DEPTH.
REQ-012 overflow  output  1  sticky: a result was dropped because the FIFO was full.

Function
REQ-013 Accumulator FSM states: S_idle (no samples held), S_accum (1..N-1 samples held).
REQ-014 S_idle + eoc: latch avg_sel into n_sel; if n_sel==0, push sar directly, stay S_idle; else acc<=sar, cnt<=1, go S_accum.
REQ-015 S_accum + eoc: if cnt+1 == 2^n_sel, push (acc+sar)>>n_sel, clear acc/cnt, go S_idle; else acc<=acc+sar, cnt<=cnt+1.
REQ-016 avg_sel changes while in S_accum are ignored until the next S_idle eoc.
REQ-017 Accumulator is 11 bits unsigned (8x255=2040 max, no overflow); result truncates (no rounding) to 8 bits.
REQ-018 Latency: dout_valid rises on the clock edge that samples the final eoc of a block when FIFO was empty (visible the cycle after that eoc).
REQ-019 FIFO is first-in first-out; dout reflects head combinationally from storage and pointers.
REQ-020 Push with FIFO full and no simultaneous pop: result dropped, FIFO unchanged, overflow<=1.
REQ-021 Push and pop in the same cycle: both performed, level unchanged, no overflow even if full.
REQ-022 Pop with FIFO empty: ignored, level stays 0.
REQ-023 Pointers wrap modulo DEPTH; level distinguishes full from empty.
REQ-024 overflow clears only on rst or flush.
REQ-025 flush: next cycle FSM=S_idle, acc=0, cnt=0, level=0, dout_valid=0, overflow=0; an eoc or pop coincident with flush is discarded.
REQ-026 eoc pulses closer than one cycle apart are not supported; back-to-back eoc in consecutive cycles are each accepted.

Reset
REQ-027 rst has priority over flush, eoc and pop.
REQ-028 Reset values: dout=0, dout_valid=0, level=0, overflow=0, FSM=S_idle, acc=0, cnt=0, n_sel=0, pointers=0.
REQ-029 FIFO storage contents need not be reset; dout is gated to 0 when empty.
REQ-030 rst mid-block discards the partial accumulation and all queued results.

Structure
REQ-031 Shared package sar_pkg holds the FSM state encoding, ACC_W=11, SAR_W=8 and the DEPTH default.
REQ-032 FIFO is a sub-module sar_result_fifo (push/data, pop, full, empty, level, flush); sar_avg_buffer contains FSM, accumulator and overflow logic.

Verification
REQ-033 avg_sel=0, eoc with sar=0x5A, dout_ready=0 -> next cycle dout=0x5A, dout_valid=1, level=1.
REQ-034 avg_sel=2, four eoc with sar=10,11,12,13 -> one push, dout=11 (46>>2), none after the first three eoc.
REQ-035 avg_sel=3, eight eoc with sar=0xFF -> dout=0xFF, no accumulator overflow.
REQ-036 avg_sel=0, dout_ready=0, DEPTH+1 eoc with sar=1..5 -> level=4, overflow=1, successive pops yield 1,2,3,4.
REQ-037 FIFO full, eoc (sar=0x33) and pop in same cycle -> level stays 4, overflow stays 0, 0x33 at tail.
REQ-038 avg_sel=2, two eoc then flush, then avg_sel=1 and two eoc of 4,6 -> single result 5, partial block discarded; rst mid-block gives the same discard.
